// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared types and constants for the PS/2 host transmit path (and the receive
// path that shares the same line conditioning).
//   ps2_state_e   : host transmitter FSM states
//   FRAME_BITS    : data + parity + stop bits shifted after the start bit
//   CMD_*         : common host-to-keyboard command bytes
//   DEF_*         : default timing for a 100 MHz system clock
//   build_frame() : assembles {stop, odd parity, data}
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    SHIFT     = 3'd2,
    ACK       = 3'd3,
    WAIT_IDLE = 3'd4
  } ps2_state_e;

  localparam int unsigned FRAME_BITS = 10;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam int unsigned DEF_CLK_HZ         = 100_000_000;
  localparam int unsigned DEF_INHIBIT_CYCLES = 12_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 2_000_000;
  localparam int unsigned DEF_FILTER_LEN     = 8;

  // Frame shifted LSB first after the start bit: 8 data bits, odd parity, stop.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter
// Conditions one asynchronous open-drain PS/2 pad: a 2-flop synchronizer, a
// stability filter that only follows the synchronized value once it has been
// constant for FILTER_LEN cycles, and a registered falling-edge strobe.
//   clk, rst_n : system clock, async active-low reset
//   pad_i      : raw pad input
//   filt_o     : filtered line level (resets high = idle bus)
//   fall_o     : one-cycle strobe, coincident with filt_o going 1 -> 0
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] CNT_LAST = FW'(FILTER_LEN - 1);

  logic [1:0]    sync_q, sync_d;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [FW-1:0] cnt_q, cnt_d;

  // Next-state for synchronizer, stability counter and edge strobe.
  always_comb begin
    sync_d = {sync_q[0], pad_i};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    fall_d = 1'b0;
    if (sync_q[1] == filt_q) begin
      // Any bounce back to the current level restarts the stability window.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = sync_q[1];
      cnt_d  = '0;
      fall_d = filt_q & ~sync_q[1];
    end else begin
      cnt_d = cnt_q + FW'(1);
    end
  end

  // Line conditioning registers; an idle PS/2 bus is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter: clock inhibit, start bit, 8 data bits LSB
// first, odd parity, stop bit and device ACK check, with a watchdog between
// device clock falling edges. Lines are driven as pull-low enables only.
//   clk, rst_n              : system clock, async active-low reset
//   ps2_clk_i, ps2_data_i   : asynchronous pad inputs
//   start, din              : one-cycle request and byte (taken in IDLE only)
//   ps2_clk_oe, ps2_data_oe : 1 = pull the line low
//   busy                    : transaction in progress (through the done cycle)
//   done                    : one-cycle end-of-transaction pulse (incl. aborts)
//   ack_err, timeout        : status, valid with done, held until next start
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = DEF_CLK_HZ,
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       start,
  input  logic [7:0] din,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int unsigned CNT_MAX =
    (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] INH_HALF  = CW'(INHIBIT_CYCLES / 2);
  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    LAST_IDX  = 4'(FRAME_BITS - 1);

  // Clock frequency only documents the default timing values.
  localparam int unsigned unused_clk_hz = CLK_HZ;

  ps2_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            idx_q, idx_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  clk_oe_q, clk_oe_d;
  logic                  data_oe_q, data_oe_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ack_err_q, ack_err_d;
  logic                  timeout_q, timeout_d;

  logic fclk_s, fclk_fall_s;
  logic fdata_s, unused_fdata_fall_s;
  logic wdog_active_s;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .pad_i  (ps2_clk_i),
    .filt_o (fclk_s),
    .fall_o (fclk_fall_s)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .pad_i  (ps2_data_i),
    .filt_o (fdata_s),
    .fall_o (unused_fdata_fall_s)
  );

  // FSM next-state, counter/index and line-enable computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    frame_d       = frame_q;
    clk_oe_d      = clk_oe_q;
    data_oe_d     = data_oe_q;
    done_d        = 1'b0;
    ack_err_d     = ack_err_q;
    timeout_d     = timeout_q;
    wdog_active_s = 1'b0;

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (start) begin
          frame_d   = build_frame(din);
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          idx_d     = 4'd0;
          clk_oe_d  = 1'b1;
          state_d   = INHIBIT;
        end else begin
          cnt_d = '0;
          idx_d = 4'd0;
        end
      end

      INHIBIT: begin
        clk_oe_d = 1'b1;
        // Start bit goes out while the clock is still held low.
        if (cnt_q == INH_HALF) begin
          data_oe_d = 1'b1;
        end else begin
          data_oe_d = data_oe_q;
        end
        if (cnt_q == INH_LAST) begin
          clk_oe_d = 1'b0;
          cnt_d    = '0;
          idx_d    = 4'd0;
          state_d  = SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SHIFT: begin
        wdog_active_s = 1'b1;
        if (fclk_fall_s) begin
          data_oe_d = ~frame_q[idx_q];
          cnt_d     = '0;
          idx_d     = idx_q + 4'd1;
          if (idx_q == LAST_IDX) begin
            state_d = ACK;
          end else begin
            state_d = SHIFT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ACK: begin
        wdog_active_s = 1'b1;
        if (fclk_fall_s) begin
          // Device pulls data low to acknowledge; a high line is a NACK.
          ack_err_d = fdata_s;
          cnt_d     = '0;
          state_d   = WAIT_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_IDLE: begin
        wdog_active_s = 1'b1;
        if (fclk_s && fdata_s) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (fclk_fall_s) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // Watchdog expiry overrides anything decided above, including a
    // same-cycle device clock edge; ack_err keeps its prior value.
    if (wdog_active_s && (cnt_q == TMO_LIMIT)) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      timeout_d = 1'b1;
      ack_err_d = ack_err_q;
      done_d    = 1'b1;
      cnt_d     = '0;
      state_d   = IDLE;
    end else begin
      timeout_d = timeout_d;
    end

    // busy covers the done cycle and drops one cycle later.
    busy_d = (state_d != IDLE) || done_d;
  end

  // State and output registers; reset releases both lines at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 4'd0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout     = timeout_q;

endmodule
